// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
// DECISION_SAMP moves to 9 when UART_RX_GLITCH_FILTER_EN is defined.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        rx_idle,
        rx_start,
        rx_data,
        rx_parity,
        rx_stop
    } rx_state_e;

`ifdef UART_RX_GLITCH_FILTER_EN
    localparam logic [3:0] DECISION_SAMP = 4'd9;
`else
    localparam logic [3:0] DECISION_SAMP = 4'd8;
`endif
    localparam logic [3:0] LAST_SAMP = 4'd15;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver: baud tick, serial line, frame
// configuration, CPU handshake pulses and the received byte with its flags.
interface uart_rx_if;
    logic       baud_clock;
    logic       rx;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic       read_rx_byte;
    logic       clear_parity;
    logic       clear_framing;
    logic [7:0] rx_byte;
    logic       rxrdy;
    logic       fifo_write_rx;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;

    modport master (
        output baud_clock, rx, bit8, parity_en, odd_n_even,
               read_rx_byte, clear_parity, clear_framing,
        input  rx_byte, rxrdy, fifo_write_rx, parity_err, framing_err, overflow
    );

    modport slave (
        input  baud_clock, rx, bit8, parity_en, odd_n_even,
               read_rx_byte, clear_parity, clear_framing,
        output rx_byte, rxrdy, fifo_write_rx, parity_err, framing_err, overflow
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchronizer and bit decision for the UART receiver; with
// UART_RX_GLITCH_FILTER_EN the bit is a 2-of-3 vote over samples 7, 8 and 9.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_i,
    input  logic       baud_clock_i,
    input  logic [3:0] samp_i,
    output logic       rx_s_o,
    output logic       bit_o,
    output logic       decide_o
);
    logic meta_q, sync_q;

    // Both flops reset to the idle-high line level so no false start follows reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
        end
    end

    assign rx_s_o   = sync_q;
    assign decide_o = baud_clock_i && (samp_i == DECISION_SAMP);

`ifdef UART_RX_GLITCH_FILTER_EN
    logic s7_q, s8_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s7_q <= 1'b1;
            s8_q <= 1'b1;
        end else if (baud_clock_i) begin
            if (samp_i == 4'd7) s7_q <= sync_q;
            if (samp_i == 4'd8) s8_q <= sync_q;
        end
    end

    // The third vote is the live sample taken at the decision point.
    assign bit_o = maj3(s7_q, s8_q, sync_q);
`else
    assign bit_o = sync_q;
`endif

endmodule

// File: rtl/uart_rx_async.sv
// uart_rx_async: 16x-oversampled UART receiver, 7/8 data bits, optional parity.
// Optional majority-vote glitch filter: define UART_RX_GLITCH_FILTER_EN.
module uart_rx_async
    import uart_rx_pkg::*;
#(
    parameter bit SYNC_RESET = 1'b0,
    parameter bit RX_FIFO    = 1'b0
) (
    input  logic     clk,
    input  logic     reset_n,
    uart_rx_if.slave bus
);
    if (SYNC_RESET) begin : g_sync_reset_unsupported
        $error("uart_rx_async: only asynchronous reset is implemented");
    end

    rx_state_e  state_q, state_d;
    logic [3:0] samp_q, samp_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       bit8_q, bit8_d, par_en_q, par_en_d, odd_q, odd_d;
    logic       pend_pe_q, pend_pe_d, pend_fe_q, pend_fe_d;
    logic       dlv_q, dlv_d, armed_q, armed_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rxrdy_q, rxrdy_d, fwr_n_q, fwr_n_d;
    logic       pe_q, pe_d, fe_q, fe_d, ovf_q, ovf_d;
    logic       rx_s, bit_val, decide, last_samp;
    logic [7:0] frame_byte;
    logic [2:0] last_idx;

    uart_rx_sampler u_sampler (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_i         (bus.rx),
        .baud_clock_i (bus.baud_clock),
        .samp_i       (samp_q),
        .rx_s_o       (rx_s),
        .bit_o        (bit_val),
        .decide_o     (decide)
    );

    assign last_samp  = bus.baud_clock && (samp_q == LAST_SAMP);
    // 7-bit frames end up in shift_q[7:1]; realign so bit 7 reads as 0.
    assign frame_byte = bit8_q ? shift_q : {1'b0, shift_q[7:1]};
    assign last_idx   = bit8_q ? 3'd7 : 3'd6;

    // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        bit8_d    = bit8_q;
        par_en_d  = par_en_q;
        odd_d     = odd_q;
        pend_pe_d = pend_pe_q;
        pend_fe_d = pend_fe_q;
        dlv_d     = 1'b0;
        armed_d   = armed_q;

        if (bus.baud_clock) samp_d = samp_q + 4'd1;

        unique case (state_q)
            rx_idle: begin
                samp_d = 4'd0;
                // After a stop bit the line must be seen high again before a new start.
                if (rx_s) armed_d = 1'b1;
                if (!rx_s && armed_q) begin
                    state_d   = rx_start;
                    bit_idx_d = 3'd0;
                    bit8_d    = bus.bit8;
                    par_en_d  = bus.parity_en;
                    odd_d     = bus.odd_n_even;
                    pend_pe_d = 1'b0;
                    pend_fe_d = 1'b0;
                end
            end
            rx_start: begin
                if (decide && bit_val) state_d = rx_idle;
                else if (last_samp)    state_d = rx_data;
            end
            rx_data: begin
                if (decide) shift_d = {bit_val, shift_q[7:1]};
                if (last_samp) begin
                    if (bit_idx_q == last_idx) state_d = par_en_q ? rx_parity : rx_stop;
                    else                       bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            rx_parity: begin
                if (decide)    pend_pe_d = ((^frame_byte) ^ bit_val) != odd_q;
                if (last_samp) state_d = rx_stop;
            end
            rx_stop: begin
                if (decide) begin
                    pend_fe_d = !bit_val;
                    dlv_d     = 1'b1;
                    armed_d   = 1'b0;
                    state_d   = rx_idle;
                end
            end
            default: state_d = rx_idle;
        endcase
    end

    // Delivery runs one clk after the stop decision; a new error beats a clear pulse.
    always_comb begin
        rx_byte_d = rx_byte_q;
        rxrdy_d   = rxrdy_q;
        fwr_n_d   = 1'b1;
        pe_d      = pe_q;
        fe_d      = fe_q;
        ovf_d     = ovf_q;

        if (bus.clear_parity)  pe_d = 1'b0;
        if (bus.clear_framing) fe_d = 1'b0;
        if (bus.read_rx_byte) begin
            rxrdy_d = 1'b0;
            ovf_d   = 1'b0;
        end

        if (dlv_q) begin
            if (pend_pe_q) pe_d = 1'b1;
            if (pend_fe_q) fe_d = 1'b1;
            if (RX_FIFO) begin
                rx_byte_d = frame_byte;
                fwr_n_d   = 1'b0;
            end else if (rxrdy_q && !bus.read_rx_byte) begin
                ovf_d = 1'b1;
            end else begin
                rx_byte_d = frame_byte;
                rxrdy_d   = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= rx_idle;
            samp_q    <= 4'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            bit8_q    <= 1'b1;
            par_en_q  <= 1'b0;
            odd_q     <= 1'b0;
            pend_pe_q <= 1'b0;
            pend_fe_q <= 1'b0;
            dlv_q     <= 1'b0;
            armed_q   <= 1'b0;
            rx_byte_q <= 8'd0;
            rxrdy_q   <= 1'b0;
            fwr_n_q   <= 1'b1;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            samp_q    <= samp_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            bit8_q    <= bit8_d;
            par_en_q  <= par_en_d;
            odd_q     <= odd_d;
            pend_pe_q <= pend_pe_d;
            pend_fe_q <= pend_fe_d;
            dlv_q     <= dlv_d;
            armed_q   <= armed_d;
            rx_byte_q <= rx_byte_d;
            rxrdy_q   <= rxrdy_d;
            fwr_n_q   <= fwr_n_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.rx_byte       = rx_byte_q;
    assign bus.rxrdy         = rxrdy_q;
    assign bus.fifo_write_rx = fwr_n_q;
    assign bus.parity_err    = pe_q;
    assign bus.framing_err   = fe_q;
    assign bus.overflow      = ovf_q;

endmodule

// File: doc/uart_rx_async.md
# uart_rx_async

Asynchronous UART receiver for CoreUARTapb: the receive-side counterpart of the TX serializer in the same core. Samples the `rx` pin with the shared 16x baud-enable pulse and recovers 7- or 8-bit frames with optional parity. Reports framing, parity and overflow errors. Delivers each byte either to a holding register (`rxrdy` handshake) or to the RX FIFO via an active-low write strobe.

## Interface
- SYNC_RESET, 0, reserved for the core-wide reset option; this block uses asynchronous reset only.
- RX_FIFO, 0, 0 = holding register with `rxrdy`; 1 = write each byte to the RX FIFO.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- baud_clock  in  1  one-clk pulse at 16x baud rate
- rx  in  1  serial line, asynchronous, idle high
- bit8  in  1  1 = 8 data bits, 0 = 7 data bits
- parity_en  in  1  parity bit present
- odd_n_even  in  1  1 = odd parity, 0 = even parity
- read_rx_byte  in  1  one-clk pulse: CPU has read `rx_byte`
- clear_parity  in  1  pulse: clear `parity_err`
- clear_framing  in  1  pulse: clear `framing_err`
- rx_byte  out  8  received data; bit 7 is 0 in 7-bit mode
- rxrdy  out  1  byte valid (RX_FIFO=0); held at 0 when RX_FIFO=1
- fifo_write_rx  out  1  active-low one-clk FIFO write strobe (RX_FIFO=1)
- parity_err, framing_err, overflow  out  1 each  sticky error flags

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. All sampling uses `rx_s`.
- A 4-bit sample counter `samp` advances on each `baud_clock`. The decision point is `samp`==8.
- State rx_idle:
  - Hold `samp`=0.
  - On `rx_s`==0, go to rx_start.
- State rx_start:
  - At the decision point, if the sampled value is 1 (false start), return to rx_idle.
  - Otherwise continue. At `samp`==15, go to rx_data.
- State rx_data:
  - Sample one bit per bit period at the decision point, LSB first, into a shift register.
  - A bit index counts 0..6 (7-bit mode) or 0..7 (8-bit mode).
  - After the last bit, at `samp`==15, go to rx_parity if `parity_en`, else go to rx_stop.
- State rx_parity:
  - At the decision point, compute `parity_err`, which sets if XOR(data bits, parity bit) != `odd_n_even`.
  - At `samp`==15, go to rx_stop.
- State rx_stop:
  - At the decision point, if the sample is 0, set `framing_err`. The byte is delivered regardless.
  - Then go to rx_idle immediately, without waiting for `samp`==15.
- Delivery with RX_FIFO=0:
  - If `rxrdy`==0: load `rx_byte` and set `rxrdy`.
  - If `rxrdy`==1: keep the old `rx_byte` and set `overflow`.
- Delivery with RX_FIFO=1:
  - Load `rx_byte` and drive `fifo_write_rx`=0 for exactly one clk.
  - The FIFO owns full detection; `overflow` never sets.
- Clearing flags:
  - `read_rx_byte` clears `rxrdy` and `overflow`.
  - If delivery and `read_rx_byte` occur in the same clk, delivery wins: `rxrdy`=1, new byte loaded, no overflow.
  - A clear pulse coincident with a new error leaves the flag set.
- `bit8`, `parity_en` and `odd_n_even` are sampled only at frame start, on the transition out of rx_idle. Mid-frame changes affect the next frame.

## Timing
- Reset values: `rx_byte`=0, `rxrdy`=0, `fifo_write_rx`=1, all error flags 0, state rx_idle, synchronizer flops 1.
- Reset mid-frame aborts the frame with no delivery.
- Input-to-`rx_s` latency is 2 clk.
- Delivery occurs 1 clk after the stop-bit decision pulse. Flags update in the same clk as delivery.
- A line held low (break) produces a byte of 0 with `framing_err`=1. The next frame is not accepted until `rx_s` returns high in rx_idle.

## Configuration
- `UART_RX_GLITCH_FILTER_EN`:
  - Defined: each bit value is the majority of the samples at `samp`=7, 8 and 9, and the decision point moves to `samp`==9. This applies to the start-bit check as well.
  - Undefined: a single sample is taken at `samp`==8. The majority registers are not built.

## Structure
- Package `uart_rx_pkg` holds:
  - the state encoding (rx_idle, rx_start, rx_data, rx_parity, rx_stop);
  - the constant DECISION_SAMP (8 or 9 per macro);
  - the constant LAST_SAMP=15.
- Sub-module `uart_rx_sampler` contains the synchronizer and the optional majority filter. It outputs `rx_s` and the decided bit value.

## Test plan
- 8N1 frame 0xA5 (TX side loopback): `rx_byte`=0xA5, `rxrdy`=1 and no error flags, delivered 1 clk after the stop decision.
- 7-bit mode, even parity, data 0x41 with parity bit 1: `rx_byte`=0x41, `parity_err`=1. Repeat with odd parity: `parity_err`=0.
- Stop bit driven 0 on byte 0x3C: `rx_byte`=0x3C, `framing_err`=1. `clear_framing` clears it.
- Two frames 0x11 then 0x22 with no `read_rx_byte`: `rx_byte`=0x11, `overflow`=1. `read_rx_byte` clears `rxrdy` and `overflow`.
- `rx` low pulse of 4 baud_clock periods: false start, return to rx_idle, no delivery. With the macro, a 1-sample high glitch mid-bit is rejected.
- RX_FIFO=1, frame 0x7E: `fifo_write_rx` is low for exactly 1 clk with `rx_byte`=0x7E, and `rxrdy` stays 0.
